// File: rtl/pa_toeplitz_feeder_pkg.sv
// Shared widths and state encoding for the privacy-amplification Toeplitz feeder.
// Shift-chain depth is derived so that PA_S words exactly fill the (K+W)-bit chain.
package pa_toeplitz_feeder_pkg;

    localparam int PA_W     = 64;
    localparam int PA_K     = 1024;
    localparam int PA_S     = (PA_K + PA_W) / PA_W;
    localparam int PA_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        ACCUM   = 2'd2,
        OUT     = 2'd3
    } pa_state_t;

endpackage

// File: rtl/pa_toeplitz_feeder.sv
// Sequences seed/key words into the Toeplitz hasher and strobes hash_valid PA_S+N+2 cycles after start.
// Backpressure: a step waits for both streams; key_en stays high through ACCUM stalls so sums survive.
module pa_toeplitz_feeder
    import pa_toeplitz_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PA_LEN_W-1:0] num_key_words,
    input  logic [PA_W-1:0]     rand_data,
    input  logic                rand_valid,
    output logic                rand_ready,
    input  logic [PA_W-1:0]     key_data,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [PA_W-1:0]     random_bit,
    output logic                shift_en,
    output logic [PA_W-1:0]     key_bit,
    output logic                key_en,
    output logic                hash_valid,
    output logic                busy,
    output logic                err
);

    localparam logic [4:0] PRE_LAST = 5'(PA_S - 1);

    pa_state_t            state;
    logic [4:0]           pre_cnt;
    logic [PA_LEN_W-1:0]  len;
    logic [PA_LEN_W-1:0]  key_cnt;
    logic                 last;
    logic                 rand_fire;
    logic                 key_fire;

    // On the final step no seed word is needed, so the key may go without one.
    always_comb begin
        last       = (key_cnt == len - PA_LEN_W'(1));
        rand_ready = 1'b0;
        key_ready  = 1'b0;
        case (state)
            PRELOAD: rand_ready = 1'b1;
            ACCUM: begin
                key_ready  = rand_valid || last;
                rand_ready = key_valid && !last;
            end
            default: ;
        endcase
    end

    assign rand_fire = rand_valid && rand_ready;
    assign key_fire  = key_valid && key_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            len        <= '0;
            key_cnt    <= '0;
            random_bit <= '0;
            shift_en   <= 1'b0;
            key_bit    <= '0;
            key_en     <= 1'b0;
            hash_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            shift_en   <= rand_fire;
            if (rand_fire) begin
                random_bit <= rand_data;
            end
            key_en     <= (state == ACCUM);
            key_bit    <= key_fire ? key_data : '0;
            hash_valid <= (state == OUT);
            err        <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_key_words == '0) begin
                            err <= 1'b1;
                        end else begin
                            len     <= num_key_words;
                            pre_cnt <= '0;
                            key_cnt <= '0;
                            state   <= PRELOAD;
                        end
                    end
                end
                PRELOAD: begin
                    if (rand_fire) begin
                        pre_cnt <= pre_cnt + 5'd1;
                        if (pre_cnt == PRE_LAST) begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (key_fire) begin
                        key_cnt <= key_cnt + PA_LEN_W'(1);
                        if (last) begin
                            state <= OUT;
                        end
                    end
                end
                OUT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pa_toeplitz_feeder.md
Name: pa_toeplitz_feeder

Overview:
- Upstream sequencer for the Bob-side privacy-amplification Toeplitz hasher.
- Pulls 64-bit random-seed words and reconciled-key words from two valid/ready streams.
- Preloads the hasher's (K+W)-bit shift chain, then streams key words while shifting in further seed words.
- Generates the one-cycle hash-valid strobe for the 1024-bit hash product; the hasher itself does not drive it.

Parameters:
- PA_W, 64, word width of the random and key streams.
- PA_K, 1024, hash output length in bits.
- PA_S, 17, shift-chain depth in words, equal to (PA_K+PA_W)/PA_W.
- LEN_W, 16, width of the key-word count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a hash when idle
- num_key_words  in  LEN_W  key words in this block; latched on an accepted start
- rand_data  in  PA_W  seed word
- rand_valid  in  1  seed word available
- rand_ready  out  1  seed word consumed this cycle
- key_data  in  PA_W  key word
- key_valid  in  1  key word available
- key_ready  out  1  key word consumed this cycle
- random_bit  out  PA_W  to hasher, registered
- shift_en  out  1  to hasher, registered
- key_bit  out  PA_W  to hasher, registered
- key_en  out  1  to hasher, registered
- hash_valid  out  1  hash product valid this cycle only
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse; start rejected

Behaviour:
- Reset: state IDLE; all outputs 0 (random_bit, key_bit, shift_en, key_en, hash_valid, err); counters cleared. A reset mid-operation aborts, and no hash_valid is issued.
- FSM: IDLE, PRELOAD, ACCUM, OUT.
- IDLE:
  - start with num_key_words != 0: latch the length, go to PRELOAD.
  - start with num_key_words == 0: err=1 next cycle, stay in IDLE.
  - start while busy is ignored.
- PRELOAD:
  - rand_ready=1, key_ready=0.
  - Each rand fire increments pre_cnt.
  - After fire number PA_S, go to ACCUM.
- ACCUM, with last = (key_cnt == len-1):
  - key_ready = key_valid ungated, as key_ready = rand_valid || last.
  - rand_ready = key_valid && !last.
  - A step fires when key fires. A seed word is fired alongside every step except the last.
  - After the last key fire, go to OUT.
- OUT: lasts one cycle, then IDLE.
- Registered outputs, given cycle t state and fires:
  - shift_en(t+1) = rand fire(t); random_bit(t+1) = rand_data(t).
  - key_en(t+1) = (state(t) == ACCUM).
  - key_bit(t+1) = key fire(t) ? key_data(t) : 0.
  - hash_valid(t+1) = (state(t) == OUT).
  - random_bit holds its value when there is no fire.
- Stall rule: key_en stays high through every ACCUM stall, with key_bit=0 and shift_en=0. The hasher MAC clears when key_en=0, so dropping key_en mid-block is forbidden. XOR with a zero key word preserves the sums.
- key_en is 0 throughout PRELOAD, which clears the MAC sums before accumulation.
- Final MAC sums are present exactly in the hash_valid cycle and cleared at its end (key_en=0). The consumer must capture in that cycle.
- Stream totals per block: PA_S+N-1 seed words and N key words.
- Latency with always-valid streams: hash_valid is asserted PA_S+N+2 cycles after the start cycle.
- start is accepted in the hash_valid cycle (state is IDLE), giving back-to-back blocks.
- Counters: pre_cnt is 5 bits and saturates only through the state change. key_cnt is LEN_W bits, with no wrap within a block.

Decomposition:
- Existing pa_parameter.v supplies PA_W, PA_K and PA_S. Add PA_LEN_W and the state encodings (IDLE=2'd0, PRELOAD=1, ACCUM=2, OUT=3) there.
- Single module; no sub-module warranted.
- The top level wires hash_valid to the hasher's consumer in place of hash_product_valid.

Test Plan:
- All-ones seed words, N=1, key word 64'h1, streams always valid.
  - Required: 17 rand fires, 1 key fire.
  - Required: hash_product = all 1024 bits set, sampled in the hash_valid cycle.
  - Required: hash_valid exactly 1 cycle, 20 cycles after start.
- N=4, random seed and key words, always valid.
  - Required: 20 rand fires, 4 key fires.
  - Required: hash matches the GF(2) Toeplitz reference model.
  - Required: hash_valid at cycle start+23.
- Same data as the previous scenario, with key_valid low for 5 cycles after key 2 and rand_valid low for 3 cycles during PRELOAD.
  - Required: identical hash.
  - Required: key_en continuously 1 during ACCUM; key_bit=0 and shift_en=0 during stalls.
- start with num_key_words=0.
  - Required: err pulse 1 cycle; busy stays 0; no ready asserted.
- rst_n low for 1 cycle mid-ACCUM.
  - Required: all outputs 0 next cycle; IDLE; no hash_valid.
  - Required: a subsequent N=2 run produces the correct hash.
- start asserted in the hash_valid cycle of a previous N=2 run.
  - Required: the second run is accepted.
  - Required: the first hash is unaffected.
  - Required: the second hash is correct, with no contamination from the first block's sums.
